conv_encoder_framer: RTL and testbench
======================================

# conv_encoder_framer

Rate-1/2, constraint-length-3 convolutional encoder with frame-based tail flushing, sitting directly upstream of `viterbi_decoder` and driving its 2-bit `cx` symbol input. Accepts one information bit per cycle through a valid/ready handshake. After every `FRAME_LEN` data bits it appends K-1 = 2 zero tail bits, so each frame ends with the trellis back in state 00, which is the state the decoder starts from after reset.

## Interface
- `FRAME_LEN`, default 16: data bits per frame; legal range 1..65535.
- `CNT_W`, default 16: width of the frame bit counter; must satisfy 2^CNT_W > FRAME_LEN.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `in_bit` input, 1 bit: information bit.
- `in_valid` input, 1 bit: `in_bit` is valid this cycle.
- `in_ready` output, 1 bit: encoder accepts a bit this cycle.
- `cx` output, 2 bits: encoded symbol; `cx[1]` = G0 output, `cx[0]` = G1 output. Connects to the decoder `cx`.
- `cx_valid` output, 1 bit: `cx` holds a new symbol this cycle.
- `sof` output, 1 bit: asserted with `cx_valid` on the first symbol of a frame.
- `eof` output, 1 bit: asserted with `cx_valid` on the last tail symbol of a frame.
- `busy` output, 1 bit: high while a frame is in progress (state DATA or TAIL).

## Operation
- **Encoder state.** `s[1:0]`: `s[1]` is the most recent input, `s[0]` the one before.
  - For input `u`: `c0 = u^s[1]^s[0]` (G0 = 111), `c1 = u^s[0]` (G1 = 101).
  - Next state: `s <= {u, s[1]}`.
- **Handshake.** A bit is accepted when `in_valid && in_ready`.
- **FSM states.** IDLE, DATA, TAIL.
- **IDLE.**
  - `in_ready` = 1, `s` = 00, `cnt` = 0.
  - On acceptance: encode, assert `sof`, set `cnt` = 1.
  - Go to DATA. If `FRAME_LEN` = 1, go to TAIL instead.
- **DATA.**
  - `in_ready` = 1.
  - Each accepted bit is encoded and increments `cnt`.
  - When the accepted bit makes `cnt == FRAME_LEN`: go to TAIL and clear `cnt`.
  - Cycles with no acceptance produce no symbol. `s` and `cnt` hold.
- **TAIL.**
  - `in_ready` = 0.
  - The encoder feeds u = 0 internally for exactly 2 consecutive cycles, one symbol each.
  - The second tail symbol carries `eof`; the FSM then returns to IDLE with `s` = 00.
  - `in_valid` is ignored in TAIL.
- **Symbol outputs.**
  - `cx_valid` is 1 only in the cycle after an accepted bit or a tail step.
  - When `cx_valid` = 0, `cx` is driven 00.
  - `sof` and `eof` are 0 whenever `cx_valid` = 0.
- **`busy`.** High in DATA and TAIL. It stays high through the cycle in which the `eof` symbol is presented.

## Timing
- **Reset (async assert).** FSM = IDLE; `s` = 00; `cnt` = 0; `cx` = 00; `cx_valid` = 0; `sof` = 0; `eof` = 0; `busy` = 0.
  - `in_ready` = 0 while `reset` is low.
  - `in_ready` = 1 in the first cycle after deassertion.
- **Reset mid-frame.** The partial frame is abandoned and no tail is emitted. The next accepted bit starts a new frame with `sof`.
- **Latency.** Symbol for an accepted bit is registered and appears 1 cycle after acceptance. Tail symbols follow at 1 symbol per cycle.
- **Throughput.** With `in_valid` held high, a frame occupies `FRAME_LEN + 2` consecutive symbol cycles. `in_ready` is low for exactly 2 cycles per frame.
- **Frame-to-frame.** A new bit may be accepted in the cycle the `eof` symbol is presented, because the FSM is already in IDLE. Back-to-back frames therefore have no symbol gap.
- **Counter wrap.** `cnt` never exceeds `FRAME_LEN` and clears on entry to TAIL.
- **Output interface.** No backpressure on `cx`: the downstream decoder consumes one symbol per valid cycle.

## Structure
- **Package `conv_code_pkg`:**
  - `K` = 3.
  - `G0` = 3'b111, `G1` = 3'b101.
  - `TAIL_LEN` = K-1.
  - FSM state enum `{IDLE, DATA, TAIL}`.
  - Function `conv_encode(u, s)` returning `{c0, c1}`.
  - The decoder side reuses the same generator constants.
- **Sub-module `conv_enc_core`:** the natural one.
  - Holds the 2-bit shift register and the generator XORs.
  - Inputs: `step`, `u`, `clear`.
  - Output: `{c0, c1}`.
  - The framer FSM, counter and output registers sit in the top level.

## Test plan
- **Basic frame.** `FRAME_LEN` = 4; input 1,0,1,1 with `in_valid` continuous from reset.
  - `cx` = 11, 10, 00, 01, then tail 01, 11.
  - `sof` on the first symbol, `eof` on the 6th.
  - `in_ready` low for exactly 2 cycles.
- **Gapped input.** Same bits with `in_valid` low for 3 cycles between bits 2 and 3.
  - Identical `cx` sequence.
  - `cx_valid` low during the gaps; `s` unchanged across them.
- **Back-to-back frames.** Two frames, 1,1,1,1 then 0,0,0,0.
  - Frame 1: 11, 01, 10, 10, tail 01, 11.
  - Frame 2: all 00.
  - `sof` of frame 2 appears immediately after `eof` of frame 1.
- **Ignored input in TAIL.** `in_valid` = 1 with `in_bit` = 1 held during TAIL.
  - Bit not accepted; tail symbols unchanged.
  - That bit is accepted in the IDLE cycle that follows.
- **Reset mid-frame.** Assert `reset` low after 2 bits of a `FRAME_LEN` = 4 frame.
  - All outputs 0 immediately.
  - Next frame 1,0,1,1 reproduces 11, 10, 00, 01, 01, 11.
- **End-to-end.** Chain to `viterbi_decoder` with a random `FRAME_LEN` = 16 payload and no channel errors.
  - Decoded `d` stream matches the payload after decoder latency.

Source files
------------

// File: rtl/conv_code_pkg.sv
// ---------------------------------------------------------------------------
// conv_code_pkg
//   Shared definitions for the rate-1/2, K=3 convolutional code. The encoder
//   framer and the downstream Viterbi decoder both use these generator
//   constants, so the two sides always agree on the code.
//
//   Contents:
//     K, G0, G1, TAIL_LEN - code parameters (G0 = 111, G1 = 101)
//     frame_state_e       - framer FSM states
//     conv_encode()       - one trellis step: returns {c0, c1}
// ---------------------------------------------------------------------------
package conv_code_pkg;

  localparam int             K        = 3;
  localparam logic [K-1:0]   G0       = 3'b111;
  localparam logic [K-1:0]   G1       = 3'b101;
  localparam int             TAIL_LEN = K - 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } frame_state_e;

  // taps = {u, s[1], s[0]}; each generator bit selects one tap.
  function automatic logic [1:0] conv_encode(input logic u, input logic [K-2:0] s);
    logic [K-1:0] taps;
    taps = {u, s};
    return {^(taps & G0), ^(taps & G1)};
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// ---------------------------------------------------------------------------
// conv_enc_core
//   Shift register and generator XORs of the K=3 convolutional encoder.
//   The coded symbol for the current input is combinational; the state
//   advances only on 'step'.
//
//   Ports:
//     clk    in   clock, rising edge
//     reset  in   asynchronous active-low reset (state -> 00)
//     step   in   advance the trellis with 'u' this cycle
//     u      in   input bit to encode
//     clear  in   force the state back to 00 (wins over step)
//     code   out  {c0, c1} for input 'u' from the current state
// ---------------------------------------------------------------------------
module conv_enc_core
  import conv_code_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       u,
  input  logic       clear,
  output logic [1:0] code
);

  // s[1] is the most recent input, s[0] the one before it.
  logic [K-2:0] s;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks are run in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s <= '0;
    end else if (clear) begin
      s <= '0;
    end else if (step) begin
      s <= {u, s[K-2:1]};
    end
  end

  assign code = conv_encode(u, s);

endmodule

// File: rtl/conv_encoder_framer.sv
// ---------------------------------------------------------------------------
// conv_encoder_framer
//   Rate-1/2, K=3 convolutional encoder with per-frame tail flushing. Takes
//   one information bit per cycle through valid/ready, and after FRAME_LEN
//   data bits injects TAIL_LEN zero bits so every frame ends in state 00,
//   the decoder's post-reset starting state.
//
//   Parameters:
//     FRAME_LEN  data bits per frame (1..65535)
//     CNT_W      frame counter width, 2**CNT_W > FRAME_LEN
//
//   Ports:
//     clk       in   clock, rising edge
//     reset     in   asynchronous active-low reset
//     in_bit    in   information bit
//     in_valid  in   in_bit is valid
//     in_ready  out  bit is accepted this cycle when in_valid is also high
//     cx        out  coded symbol {G0 out, G1 out}, 00 when not valid
//     cx_valid  out  cx holds a new symbol
//     sof       out  first symbol of a frame
//     eof       out  last tail symbol of a frame
//     busy      out  frame in progress, including the eof symbol cycle
// ---------------------------------------------------------------------------
module conv_encoder_framer
  import conv_code_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] cx,
  output logic       cx_valid,
  output logic       sof,
  output logic       eof,
  output logic       busy
);

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN);
  localparam int               TAIL_W     = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(TAIL_LEN - 1);

  frame_state_e      state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [TAIL_W-1:0] tail_idx;

  logic       accept;
  logic       in_tail;
  logic       core_step;
  logic       core_u;
  logic       core_clear;
  logic [1:0] code;

  // in_ready follows the registered state but is forced low while reset is
  // held, so it is already high in the first cycle after release.
  assign in_tail  = (state == TAIL);
  assign in_ready = reset && !in_tail;
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = cnt + 1'b1;

  // Tail steps feed zeros; in_bit is ignored there. Idle cycles pin the
  // trellis at 00 so a frame always starts from the decoder's start state.
  assign core_step  = accept || in_tail;
  assign core_u     = in_tail ? 1'b0 : in_bit;
  assign core_clear = (state == IDLE) && !accept;

  conv_enc_core u_core (
    .clk   (clk),
    .reset (reset),
    .step  (core_step),
    .u     (core_u),
    .clear (core_clear),
    .code  (code)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      tail_idx <= '0;
      cx       <= 2'b00;
      cx_valid <= 1'b0;
      sof      <= 1'b0;
      eof      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // NOTE: the symbol outputs get a default before the case so that any
      // cycle without a step presents 00/0 rather than holding old values.
      cx       <= 2'b00;
      cx_valid <= 1'b0;
      sof      <= 1'b0;
      eof      <= 1'b0;
      busy     <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            cx       <= code;
            cx_valid <= 1'b1;
            sof      <= 1'b1;
            busy     <= 1'b1;
            if (FRAME_LEN == 1) begin
              state <= TAIL;
              cnt   <= '0;
            end else begin
              state <= DATA;
              cnt   <= CNT_W'(1);
            end
          end
        end

        DATA: begin
          busy <= 1'b1;
          if (accept) begin
            cx       <= code;
            cx_valid <= 1'b1;
            if (cnt_inc == FRAME_LAST) begin
              state <= TAIL;
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        TAIL: begin
          // busy stays high into the cycle that presents the eof symbol.
          busy     <= 1'b1;
          cx       <= code;
          cx_valid <= 1'b1;
          if (tail_idx == TAIL_LAST) begin
            eof      <= 1'b1;
            state    <= IDLE;
            tail_idx <= '0;
          end else begin
            tail_idx <= tail_idx + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// ---------------------------------------------------------------------------
// tb_conv_encoder_framer
//   Scoreboard bench for conv_encoder_framer with FRAME_LEN = 4. Stimulus
//   pushes the hand-computed symbols of each frame into a queue; a monitor
//   pops one entry per cx_valid cycle and compares cx/sof/eof/busy and, where
//   the symbol must follow its predecessor directly, the cycle spacing.
// ---------------------------------------------------------------------------
module tb_conv_encoder_framer;

  localparam int FL = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] cx;
  logic       cx_valid;
  logic       sof;
  logic       eof;
  logic       busy;

  typedef struct packed {
    logic [1:0] cx;
    logic       sof;
    logic       eof;
    logic       contig;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_valid_cyc = -100;

  conv_encoder_framer #(.FRAME_LEN(FL), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cx       (cx),
    .cx_valid (cx_valid),
    .sof      (sof),
    .eof      (eof),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (cx_valid) begin
        check("symbol_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("cx", 32'(cx), 32'(mon_e.cx));
          check("sof", 32'(sof), 32'(mon_e.sof));
          check("eof", 32'(eof), 32'(mon_e.eof));
          check("busy_with_symbol", 32'(busy), 32'd1);
          if (mon_e.contig) check("no_gap", 32'(cyc - last_valid_cyc), 32'd1);
        end
        last_valid_cyc = cyc;
      end else begin
        check("quiet_outputs", {29'd0, cx, sof | eof}, 32'd0);
      end
    end
  end

  // Six symbols of one frame, first in syms[11:10]; contig bit i (MSB = first
  // symbol) demands that symbol follow the previous one with no gap.
  task automatic push_frame(input logic [11:0] syms, input logic [5:0] contig);
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      e.cx     = syms[11-2*i -: 2];
      e.sof    = (i == 0);
      e.eof    = (i == 5);
      e.contig = contig[5-i];
      exp_q.push_back(e);
    end
  endtask

  // Independent reference: tap-mask form of the K=3 code, tail appended.
  function automatic logic [11:0] ref_enc(input logic [3:0] bits);
    logic [1:0]  st;
    logic [2:0]  r;
    logic        u;
    logic [11:0] o;
    st = 2'b00;
    o  = '0;
    for (int i = 0; i < 6; i++) begin
      u = (i < 4) ? bits[3-i] : 1'b0;
      r = {u, st};
      o[11-2*i -: 2] = {^(r & 3'b111), ^(r & 3'b101)};
      st = {u, st[1]};
    end
    return o;
  endfunction

  task automatic send_bit(input logic b);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = b;
      ok       = in_ready;
      n++;
      if (ok) @(posedge clk);
    end
    if (!ok) check("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_bits(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) send_bit(bits[i]);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          low_cnt;
    logic [3:0]  rb;

    // Reset state.
    #2;
    check("reset_outputs", {26'd0, cx, cx_valid, sof, eof, busy}, 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // Basic frame, continuous input.
    push_frame(12'b11_10_00_01_01_11, 6'b011111);
    send_bits(4'b1011);
    @(negedge clk);
    in_valid = 1'b0;
    low_cnt  = 0;
    while (!in_ready && low_cnt < 10) begin
      low_cnt++;
      @(negedge clk);
    end
    check("ready_low_cycles", 32'(low_cnt), 32'd2);
    idle(3);
    check("idle_busy", 32'(busy), 32'd0);

    // Gapped input: 3 idle cycles between bits 2 and 3.
    push_frame(12'b11_10_00_01_01_11, 6'b010111);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("gap_cx_valid0", 32'(cx_valid), 32'd1);
    @(negedge clk);
    check("gap_cx_valid1", 32'(cx_valid), 32'd0);
    @(negedge clk);
    check("gap_cx_valid2", 32'(cx_valid), 32'd0);
    send_bit(1'b1);
    send_bit(1'b1);
    idle(4);

    // Back-to-back frames 1111 then 0000.
    push_frame(12'b11_01_10_10_01_11, 6'b011111);
    push_frame(12'b00_00_00_00_00_00, 6'b111111);
    send_bits(4'b1111);
    send_bits(4'b0000);
    idle(4);

    // in_bit = 1 held valid through TAIL: ignored there, accepted in IDLE.
    push_frame(12'b11_10_00_01_01_11, 6'b011111);
    push_frame(12'b11_10_00_01_01_11, 6'b111111);
    send_bits(4'b1011);
    send_bits(4'b1011);
    idle(4);

    // Reset mid-frame after 2 bits.
    exp_q.push_back('{cx: 2'b11, sof: 1'b1, eof: 1'b0, contig: 1'b0});
    exp_q.push_back('{cx: 2'b10, sof: 1'b0, eof: 1'b0, contig: 1'b1});
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    #2;
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midreset_outputs", {26'd0, cx, cx_valid, sof, eof, busy}, 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd0);
    check("midreset_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    push_frame(12'b11_10_00_01_01_11, 6'b011111);
    send_bits(4'b1011);
    idle(4);

    // Three random payloads back-to-back against the reference encoder.
    for (int f = 0; f < 3; f++) begin
      rb = 4'($urandom_range(0, 15));
      push_frame(ref_enc(rb), (f == 0) ? 6'b011111 : 6'b111111);
      send_bits(rb);
    end
    idle(6);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);
    check("final_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
